// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types and encodings for the multi-cycle control FSM
package ctrl_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] S_BOOT   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    typedef enum logic [2:0] {
        ST_BOOT   = S_BOOT,
        ST_FETCH  = S_FETCH,
        ST_DECODE = S_DECODE,
        ST_EXEC   = S_EXEC,
        ST_MEM    = S_MEM,
        ST_WB     = S_WB,
        ST_TRAP   = S_TRAP
    } state_e;

    typedef enum logic [3:0] {
        IC_OP, IC_OPIMM, IC_LOAD, IC_STORE, IC_BRANCH,
        IC_JAL, IC_JALR, IC_LUI, IC_AUIPC
    } iclass_e;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_ALU   = 2'b10;

    localparam logic [1:0] WB_ALU   = 2'b00;
    localparam logic [1:0] WB_MEM   = 2'b01;
    localparam logic [1:0] WB_PC4   = 2'b10;
    localparam logic [1:0] WB_UTYPE = 2'b11;

    localparam logic [1:0] U_NONE   = 2'b00;
    localparam logic [1:0] U_LUI    = 2'b01;
    localparam logic [1:0] U_AUIPC  = 2'b10;

    localparam logic [1:0] TC_NONE     = 2'b00;
    localparam logic [1:0] TC_ILLEGAL  = 2'b01;
    localparam logic [1:0] TC_FETCH_TO = 2'b10;
    localparam logic [1:0] TC_DATA_TO  = 2'b11;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - shared instruction/data memory request port
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic mem_ack;

    modport master (output mem_req, output mem_we, input mem_ack);
    modport slave  (input mem_req, input mem_we, output mem_ack);
endinterface

// File: rtl/instr_classify.sv
// rtl/instr_classify.sv - opcode to instruction class mapping with illegal flag
module instr_classify
    import ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output iclass_e    o_iclass,
    output logic       o_illegal
);

    always_comb begin
        o_iclass  = IC_OP;
        o_illegal = 1'b0;
        case (i_opcode)
            OPC_BRANCH: o_iclass = IC_BRANCH;
            OPC_JAL:    o_iclass = IC_JAL;
            OPC_JALR:   o_iclass = IC_JALR;
            OPC_LUI:    o_iclass = IC_LUI;
            OPC_AUIPC:  o_iclass = IC_AUIPC;
            OPC_LOAD:   o_iclass = IC_LOAD;
            OPC_STORE:  o_iclass = IC_STORE;
            OPC_OPIMM:  o_iclass = IC_OPIMM;
            OPC_OP:     o_iclass = IC_OP;
            default:    o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - fetch/decode/exec/mem/wb sequencer for the multi-cycle RV32I core
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
)(
    input  logic                     clk,
    input  logic                     rst_n,
    multicycle_ctrl_if.master        mem_bus,
    input  logic [6:0]               opcode,
    input  logic                     br_taken,
    output logic                     ir_we,
    output logic                     pc_we,
    output logic [1:0]               pc_sel,
    output logic                     rf_we,
    output logic [1:0]               wb_sel,
    output logic [1:0]               u_control,
    output logic                     trap,
    output logic [1:0]               trap_cause
);

    localparam int TO_W     = $clog2(MEM_TIMEOUT + 2);
    localparam int TO_LIMIT = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LIMIT);

    logic [2:0]      r_state;
    logic [2:0]      w_next;
    iclass_e         r_class;
    iclass_e         w_dec_class;
    logic            w_illegal;
    logic [TO_W-1:0] r_to_cnt;
    logic [1:0]      r_cause;
    logic [1:0]      w_next_cause;
    logic            w_waiting;
    logic            w_expired;

    instr_classify u_classify (
        .i_opcode  (opcode),
        .o_iclass  (w_dec_class),
        .o_illegal (w_illegal)
    );

    assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_bus.mem_ack;
    // An ack in the last allowed cycle takes priority because w_waiting is then low.
    assign w_expired = (MEM_TIMEOUT > 0) && w_waiting && (r_to_cnt == TO_LAST);

    always_comb begin
        w_next       = r_state;
        w_next_cause = r_cause;
        case (r_state)
            S_BOOT: w_next = S_FETCH;
            S_FETCH: begin
                if (mem_bus.mem_ack) begin
                    w_next = S_DECODE;
                end else if (w_expired) begin
                    w_next       = S_TRAP;
                    w_next_cause = TC_FETCH_TO;
                end
            end
            S_DECODE: begin
                if (w_illegal) begin
                    w_next       = S_TRAP;
                    w_next_cause = TC_ILLEGAL;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                case (r_class)
                    IC_LOAD, IC_STORE: w_next = S_MEM;
                    IC_OP, IC_OPIMM:   w_next = S_WB;
                    default:           w_next = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (mem_bus.mem_ack) begin
                    w_next = (r_class == IC_STORE) ? S_FETCH : S_WB;
                end else if (w_expired) begin
                    w_next       = S_TRAP;
                    w_next_cause = TC_DATA_TO;
                end
            end
            S_WB:    w_next = S_FETCH;
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_BOOT;
            r_class  <= IC_OP;
            r_to_cnt <= '0;
            r_cause  <= TC_NONE;
        end else begin
            r_state <= w_next;
            r_cause <= w_next_cause;
            if ((r_state == S_DECODE) && !w_illegal) begin
                r_class <= w_dec_class;
            end
            if (w_next != r_state) begin
                r_to_cnt <= '0;
            end else if (w_waiting) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
        end
    end

    // Only the ack-cycle strobes (ir_we, pc_we on a store) look at mem_ack.
    always_comb begin
        mem_bus.mem_req = 1'b0;
        mem_bus.mem_we  = 1'b0;
        ir_we           = 1'b0;
        pc_we           = 1'b0;
        pc_sel          = PC_PLUS4;
        rf_we           = 1'b0;
        wb_sel          = WB_ALU;
        u_control       = U_NONE;
        trap            = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_bus.mem_req = 1'b1;
                ir_we           = mem_bus.mem_ack;
            end
            S_EXEC: begin
                case (r_class)
                    IC_BRANCH: begin
                        pc_we  = 1'b1;
                        pc_sel = br_taken ? PC_IMM : PC_PLUS4;
                    end
                    IC_JAL, IC_JALR: begin
                        pc_we  = 1'b1;
                        pc_sel = (r_class == IC_JALR) ? PC_ALU : PC_IMM;
                        rf_we  = 1'b1;
                        wb_sel = WB_PC4;
                    end
                    IC_LUI, IC_AUIPC: begin
                        pc_we     = 1'b1;
                        rf_we     = 1'b1;
                        wb_sel    = WB_UTYPE;
                        u_control = (r_class == IC_LUI) ? U_LUI : U_AUIPC;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_bus.mem_req = 1'b1;
                mem_bus.mem_we  = (r_class == IC_STORE);
                pc_we           = mem_bus.mem_ack && (r_class == IC_STORE);
            end
            S_WB: begin
                rf_we  = 1'b1;
                wb_sel = (r_class == IC_LOAD) ? WB_MEM : WB_ALU;
                pc_we  = 1'b1;
            end
            S_TRAP:  trap = 1'b1;
            default: ;
        endcase
    end

    assign trap_cause = r_cause;

endmodule
